// File: rtl/skinny_subcells_dom1_serial_ctrl.sv
// Byte-serial SubCells sequencer for a 2-share (first-order DOM) SKINNY-128 datapath.
// Optional macro SKINNY_SBOX_PRECHARGE_EN: zero the S-box input wires for one cycle before each load.

module skinny_subcells_dom1_serial_ctrl_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_ld0,
    input  logic [7:0] i_ld1,
    input  logic       i_wr,
    input  logic [7:0] i_wd0,
    input  logic [7:0] i_wd1,
    output logic [7:0] o_b0,
    output logic [7:0] o_b1
);
    // One byte of each share, each in its own register; the shares never meet here.
    logic [7:0] r_b0;
    logic [7:0] r_b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b0 <= '0;
        end else if (i_load) begin
            r_b0 <= i_ld0;
        end else if (i_wr) begin
            r_b0 <= i_wd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b1 <= '0;
        end else if (i_load) begin
            r_b1 <= i_ld1;
        end else if (i_wr) begin
            r_b1 <= i_wd1;
        end
    end

    assign o_b0 = r_b0;
    assign o_b1 = r_b1;
endmodule

module skinny_subcells_dom1_serial_ctrl #(
    parameter int HOLD_CYCLES = 4,   // must be >= 4 (S-box latency)
    parameter int NBYTES      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   state0_i,
    input  logic [8*NBYTES-1:0]   state1_i,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   state0_o,
    output logic [8*NBYTES-1:0]   state1_o,
    input  logic [15:0]           rnd_i,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic [7:0]            sbox_si0_o,
    output logic [7:0]            sbox_si1_o,
    output logic [15:0]           sbox_r_o,
    input  logic [7:0]            sbox_bo0_i,
    input  logic [7:0]            sbox_bo1_i
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = $clog2(HOLD_CYCLES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RND  = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
`ifdef SKINNY_SBOX_PRECHARGE_EN
    localparam logic [2:0] S_PRE  = 3'd4;
`endif

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_si0;
    logic [7:0]    r_si1;
    logic [15:0]   r_rm;
`ifdef SKINNY_SBOX_PRECHARGE_EN
    logic [15:0]   r_rnd_hold;
`endif

    logic [NBYTES-1:0][7:0] w_sh0;
    logic [NBYTES-1:0][7:0] w_sh1;
    logic [7:0]             w_sel0;
    logic [7:0]             w_sel1;
    logic                   w_load;
    logic                   w_cnt_last;
    logic                   w_cap;
    logic                   w_last_byte;

    assign w_load      = (r_state == S_IDLE) && start;
    assign w_cnt_last  = (r_cnt == CW'(HOLD_CYCLES - 1));
    assign w_cap       = (r_state == S_HOLD) && w_cnt_last;
    assign w_last_byte = (r_idx == IW'(NBYTES - 1));
    assign w_sel0      = w_sh0[r_idx];
    assign w_sel1      = w_sh1[r_idx];

    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        skinny_subcells_dom1_serial_ctrl_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_load(w_load),
            .i_ld0 (state0_i[8*g +: 8]),
            .i_ld1 (state1_i[8*g +: 8]),
            .i_wr  (w_cap && (r_idx == IW'(g))),
            .i_wd0 (sbox_bo0_i),
            .i_wd1 (sbox_bo1_i),
            .o_b0  (w_sh0[g]),
            .o_b1  (w_sh1[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_si0      <= '0;
            r_si1      <= '0;
            r_rm       <= '0;
`ifdef SKINNY_SBOX_PRECHARGE_EN
            r_rnd_hold <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= S_RND;
                    end
                end
                S_RND: begin
                    if (rnd_valid) begin
`ifdef SKINNY_SBOX_PRECHARGE_EN
                        // Park the wires at zero so consecutive bytes never toggle against each other.
                        r_si0      <= '0;
                        r_si1      <= '0;
                        r_rm       <= '0;
                        r_rnd_hold <= rnd_i;
                        r_state    <= S_PRE;
`else
                        r_si0   <= w_sel0;
                        r_si1   <= w_sel1;
                        r_rm    <= rnd_i;
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
`endif
                    end
                end
`ifdef SKINNY_SBOX_PRECHARGE_EN
                S_PRE: begin
                    r_si0   <= w_sel0;
                    r_si1   <= w_sel1;
                    r_rm    <= r_rnd_hold;
                    r_cnt   <= '0;
                    r_state <= S_HOLD;
                end
`endif
                S_HOLD: begin
                    if (w_cnt_last) begin
                        if (w_last_byte) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_RND;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign rnd_ready  = (r_state == S_RND);
    assign state0_o   = w_sh0;
    assign state1_o   = w_sh1;
    assign sbox_si0_o = r_si0;
    assign sbox_si1_o = r_si1;
    assign sbox_r_o   = r_rm;
endmodule

// File: tb/tb_skinny_subcells_dom1_serial_ctrl.sv
// Directed bench for skinny_subcells_dom1_serial_ctrl with a 4-cycle masked S-box model attached.
// Build with SKINNY_SBOX_PRECHARGE_EN defined to exercise the precharge timing.

module tb_skinny_subcells_dom1_serial_ctrl;
`ifdef SKINNY_SBOX_PRECHARGE_EN
    localparam int PERB = 6;
`else
    localparam int PERB = 5;
`endif
    localparam int EXP_CYC = 16 * PERB + 2;

    logic         clk, rst_n, start, busy, done, rnd_valid, rnd_ready;
    logic [127:0] state0_i, state1_i, state0_o, state1_o;
    logic [15:0]  rnd_i, sbox_r_o;
    logic [7:0]   sbox_si0_o, sbox_si1_o, sbox_bo0_i, sbox_bo1_i;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int hs, stall_byte, stall_left, run_len;
    bit mon_en;
    logic [31:0] prev_sb, cur_sb, stall_si;
    logic [15:0] p1, p2, p3;

    skinny_subcells_dom1_serial_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state0_i(state0_i), .state1_i(state1_i),
        .busy(busy), .done(done),
        .state0_o(state0_o), .state1_o(state1_o),
        .rnd_i(rnd_i), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .sbox_si0_o(sbox_si0_o), .sbox_si1_o(sbox_si1_o), .sbox_r_o(sbox_r_o),
        .sbox_bo0_i(sbox_bo0_i), .sbox_bo1_i(sbox_bo1_i)
    );

    always #5 clk = ~clk;

    // SKINNY-128 S-box, only the entries the directed vectors reach.
    function automatic logic [7:0] sb(input logic [7:0] x);
        case (x)
            8'h00: sb = 8'h65; 8'h01: sb = 8'h4c; 8'h02: sb = 8'h6a; 8'h03: sb = 8'h42;
            8'h04: sb = 8'h4b; 8'h05: sb = 8'h63; 8'h06: sb = 8'h43; 8'h07: sb = 8'h6b;
            8'h08: sb = 8'h55; 8'h09: sb = 8'h75; 8'h0a: sb = 8'h5a; 8'h0b: sb = 8'h7a;
            8'h0c: sb = 8'h53; 8'h0d: sb = 8'h73; 8'h0e: sb = 8'h5b; 8'h0f: sb = 8'h7b;
            8'hff: sb = 8'hff;
            default: sb = x ^ 8'ha5;
        endcase
    endfunction

    // Masked S-box with result settling on its 4th cycle; remasked by the refresh bits.
    always @(posedge clk) begin
        p1 <= {sb(sbox_si0_o ^ sbox_si1_o) ^ sbox_r_o[7:0] ^ sbox_r_o[15:8],
               sbox_r_o[7:0] ^ sbox_r_o[15:8]};
        p2 <= p1;
        p3 <= p2;
    end
    assign sbox_bo0_i = p3[15:8];
    assign sbox_bo1_i = p3[7:0];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) if (rnd_ready && rnd_valid) hs++;

    // PRNG driver with an optional 7-cycle stall in front of byte stall_byte.
    always @(negedge clk) begin
        rnd_i = 16'($urandom);
        if (stall_left > 0 && hs == stall_byte && (rnd_ready || stall_left < 7)) begin
            if (stall_left == 7) stall_si = {sbox_si0_o, sbox_si1_o, sbox_r_o};
            else begin
                check("stall_rdy", rnd_ready, 1);
                check("stall_si", {sbox_si0_o, sbox_si1_o, sbox_r_o}, stall_si);
            end
            rnd_valid = 0;
            stall_left--;
        end else rnd_valid = 1;
    end

    // Every non-zero S-box input set must have been held for at least HOLD_CYCLES cycles.
    always @(negedge clk) begin
        cur_sb = {sbox_si0_o, sbox_si1_o, sbox_r_o};
        if (cur_sb !== prev_sb) begin
            if (mon_en && prev_sb != 0) check("sbox_stable", run_len >= 4, 1);
            run_len = 1;
            prev_sb = cur_sb;
        end else run_len++;
    end

    task automatic run_op(input logic [127:0] s0, input logic [127:0] s1, input int stb,
                          input int exp_cyc, input logic [127:0] exp_x, input string tag,
                          input bit dbl);
        int n;
        @(negedge clk);
        state0_i = s0; state1_i = s1; hs = 0; stall_byte = stb;
        stall_left = (stb >= 0) ? 7 : 0;
        start = 1;
        @(negedge clk);
        start = 0;
        n = 1;
        check({tag, "_busy"}, busy, 1);
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (dbl && n == 20) begin start = 1; state0_i = ~s0; end
            else start = 0;
        end
        start = 0;
        check({tag, "_cycles"}, n + 1, exp_cyc);
        check({tag, "_xor"}, state0_o ^ state1_o, exp_x);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [127:0] r, seq, tbl, x;
        int n;
        clk = 0; rst_n = 0; start = 0; state0_i = '0; state1_i = '0;
        rnd_i = '0; rnd_valid = 1; hs = 0; stall_byte = -1; stall_left = 0;
        mon_en = 0; run_len = 0; prev_sb = '0;
        seq = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        tbl = 128'h7b5b7353_7a5a7555_6b43634b_426a4c65;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdy", rnd_ready, 0);
        check("rst_s0", state0_o, 0);
        check("rst_s1", state1_o, 0);
        check("rst_sbox", {sbox_si0_o, sbox_si1_o, sbox_r_o}, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); mon_en = 1;

        run_op('0, '0, -1, EXP_CYC, {16{8'h65}}, "zero", 0);

        r = {$urandom, $urandom, $urandom, $urandom};
        run_op(r, r ^ {128{1'b1}}, -1, EXP_CYC, {16{8'hff}}, "ff", 0);

        run_op(seq, '0, -1, EXP_CYC, tbl, "seq", 0);
        x = state0_o ^ state1_o;
        check("seq_byte1", x[15:8], 8'h4c);

        run_op(seq, '0, 3, EXP_CYC + 7, tbl, "stall", 0);

        r = {$urandom, $urandom, $urandom, $urandom};
        run_op(r, r ^ {128{1'b1}}, -1, EXP_CYC, {16{8'hff}}, "dbl_start", 1);

        // Abort during the byte-9 evaluation window.
        @(negedge clk);
        state0_i = seq; state1_i = '0; hs = 0; stall_byte = -1; start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (hs < 10 && n < 200) begin @(negedge clk); n++; end
        check("rst_reach_b9", hs, 10);
        @(negedge clk);
        @(negedge clk);
        mon_en = 0;
        rst_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rdy", rnd_ready, 0);
        check("mid_rst_s0", state0_o, 0);
        check("mid_rst_s1", state1_o, 0);
        check("mid_rst_sbox", {sbox_si0_o, sbox_si1_o, sbox_r_o}, 0);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {busy, done}, 0);
        end
        mon_en = 1;
        run_op('0, '0, -1, EXP_CYC, {16{8'h65}}, "after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
